fas_freq_analysis: RTL

Frequency-analysis stage of the FAS datapath. It sits directly downstream of the FFT block. It captures each 16-bin complex FFT frame on `fft_valid` and computes the squared magnitude of one bin per cycle. It then reports the index of the strongest bin on `freq`, with a one-cycle `done` pulse per frame.

---
 rtl/fas_pkg.sv | 22 ++
 rtl/fas_mag_sq.sv | 21 ++
 rtl/fas_freq_analysis.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/fas_pkg.sv
// Shared FAS datapath definitions used by the FIR, FFT and frequency-analysis blocks.
// Holds the bin/sample widths, the complex FFT word layout and the analysis FSM states.
package fas_pkg;

    localparam int unsigned N_BINS = 16;
    localparam int unsigned DW     = 16;
    localparam int unsigned PROD_W = 2 * DW;
    localparam int unsigned MAG_W  = 2 * DW + 1;
    localparam int unsigned CNT_W  = 4;

    // One complex FFT bin: real part in the upper half, imaginary in the lower half.
    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } fft_word_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/fas_mag_sq.sv
// Combinational squared magnitude of one complex bin: mag = re^2 + im^2.
// Ports: re, im - signed DW-bit components; mag - unsigned MAG_W-bit result.
module fas_mag_sq
    import fas_pkg::*;
(
    input  logic signed [DW-1:0]    re,
    input  logic signed [DW-1:0]    im,
    output logic        [MAG_W-1:0] mag
);

    logic signed [PROD_W-1:0] re_sq;
    logic signed [PROD_W-1:0] im_sq;

    // Each square is non-negative and fits PROD_W bits even for -2^(DW-1).
    assign re_sq = PROD_W'(re) * PROD_W'(re);
    assign im_sq = PROD_W'(im) * PROD_W'(im);

    // One extra bit absorbs the carry of the sum, so it never wraps.
    assign mag = {1'b0, re_sq} + {1'b0, im_sq};

endmodule

// File: rtl/fas_freq_analysis.sv
// Frequency-analysis stage: captures a 16-bin FFT frame, scans one bin per cycle for the
// largest squared magnitude and reports its index.
// Ports: clk, rst (async active-low); fft_valid + fft_d0..fft_d15 frame input;
//        done (1-cycle pulse), freq (peak index), peak_mag (peak value), overrun (dropped frame).
module fas_freq_analysis
    import fas_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               fft_valid,
    input  logic [PROD_W-1:0]  fft_d0,
    input  logic [PROD_W-1:0]  fft_d1,
    input  logic [PROD_W-1:0]  fft_d2,
    input  logic [PROD_W-1:0]  fft_d3,
    input  logic [PROD_W-1:0]  fft_d4,
    input  logic [PROD_W-1:0]  fft_d5,
    input  logic [PROD_W-1:0]  fft_d6,
    input  logic [PROD_W-1:0]  fft_d7,
    input  logic [PROD_W-1:0]  fft_d8,
    input  logic [PROD_W-1:0]  fft_d9,
    input  logic [PROD_W-1:0]  fft_d10,
    input  logic [PROD_W-1:0]  fft_d11,
    input  logic [PROD_W-1:0]  fft_d12,
    input  logic [PROD_W-1:0]  fft_d13,
    input  logic [PROD_W-1:0]  fft_d14,
    input  logic [PROD_W-1:0]  fft_d15,
    output logic               done,
    output logic [CNT_W-1:0]   freq,
    output logic [MAG_W-1:0]   peak_mag,
    output logic               overrun
);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    fft_word_t        frame_buf  [N_BINS];
    fft_word_t        frame_in_c [N_BINS];
    logic [MAG_W-1:0] max_q;
    logic [CNT_W-1:0] idx_q;

    logic             capture_c;
    logic             last_c;
    logic             drop_c;
    fft_word_t        cur_c;
    logic [MAG_W-1:0] mag_c;
    logic             upd_c;
    logic [MAG_W-1:0] max_new_c;
    logic [CNT_W-1:0] idx_new_c;

    // Gather the flat input words into one indexable frame.
    assign frame_in_c[0]  = fft_d0;
    assign frame_in_c[1]  = fft_d1;
    assign frame_in_c[2]  = fft_d2;
    assign frame_in_c[3]  = fft_d3;
    assign frame_in_c[4]  = fft_d4;
    assign frame_in_c[5]  = fft_d5;
    assign frame_in_c[6]  = fft_d6;
    assign frame_in_c[7]  = fft_d7;
    assign frame_in_c[8]  = fft_d8;
    assign frame_in_c[9]  = fft_d9;
    assign frame_in_c[10] = fft_d10;
    assign frame_in_c[11] = fft_d11;
    assign frame_in_c[12] = fft_d12;
    assign frame_in_c[13] = fft_d13;
    assign frame_in_c[14] = fft_d14;
    assign frame_in_c[15] = fft_d15;

    // Single shared squarer, fed with the bin selected by the counter.
    assign cur_c = frame_buf[cnt];

    fas_mag_sq u_mag_sq (
        .re  (cur_c.re),
        .im  (cur_c.im),
        .mag (mag_c)
    );

    // Strict compare keeps the lowest index on ties.
    assign upd_c     = (mag_c > max_q);
    assign max_new_c = upd_c ? mag_c : max_q;
    assign idx_new_c = upd_c ? cnt : idx_q;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and control strobes.
    always_comb begin
        state_next = state;
        capture_c  = 1'b0;
        last_c     = 1'b0;
        drop_c     = 1'b0;
        unique case (state)
            IDLE: begin
                if (fft_valid) begin
                    capture_c  = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (cnt == CNT_W'(N_BINS - 1)) begin
                    last_c = 1'b1;
                    if (fft_valid) begin
                        capture_c = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (fft_valid) begin
                    drop_c = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Frame buffer, scan counter, running maximum and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            max_q    <= '0;
            idx_q    <= '0;
            done     <= 1'b0;
            freq     <= '0;
            peak_mag <= '0;
            overrun  <= 1'b0;
            for (int i = 0; i < int'(N_BINS); i++) begin
                frame_buf[i] <= '0;
            end
        end else begin
            done    <= last_c;
            overrun <= drop_c;
            if (last_c) begin
                freq     <= idx_new_c;
                peak_mag <= max_new_c;
            end
            if (capture_c) begin
                frame_buf <= frame_in_c;
                cnt       <= '0;
                max_q     <= '0;
                idx_q     <= '0;
            end else if (state == BUSY) begin
                cnt   <= cnt + CNT_W'(1);
                max_q <= max_new_c;
                idx_q <= idx_new_c;
            end
        end
    end

endmodule
